// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback path.
// The state encodings double as the o_state debug code seen by display logic.
package audio_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Key, recorder, player and SRAM signals of the record/playback sequencer.
// All keys and command outputs are single-cycle pulses; no valid/ready handshake is involved.
interface rec_play_ctrl_if #(
    parameter int ADDR_W = audio_pkg::ADDR_W,
    parameter int DATA_W = audio_pkg::DATA_W
);
    logic              i_key_start;
    logic              i_key_pause;
    logic              i_key_stop;
    logic              i_mode;
    logic              o_rec_start;
    logic              o_rec_pause;
    logic              o_rec_stop;
    logic [ADDR_W-1:0] i_rec_addr;
    logic [DATA_W-1:0] i_rec_data;
    logic              o_play_start;
    logic              o_play_pause;
    logic              o_play_stop;
    logic [ADDR_W-1:0] i_play_addr;
    logic [DATA_W-1:0] o_play_data;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wdata;
    logic              o_sram_we;
    logic [DATA_W-1:0] i_sram_rdata;

    // master: the sequencer itself; slave: keys, recorder, player and SRAM around it
    modport master (
        input  i_key_start, i_key_pause, i_key_stop, i_mode,
        input  i_rec_addr, i_rec_data, i_play_addr, i_sram_rdata,
        output o_rec_start, o_rec_pause, o_rec_stop,
        output o_play_start, o_play_pause, o_play_stop,
        output o_play_data, o_sram_addr, o_sram_wdata, o_sram_we
    );

    modport slave (
        output i_key_start, i_key_pause, i_key_stop, i_mode,
        output i_rec_addr, i_rec_data, i_play_addr, i_sram_rdata,
        input  o_rec_start, o_rec_pause, o_rec_stop,
        input  o_play_start, o_play_pause, o_play_stop,
        input  o_play_data, o_sram_addr, o_sram_wdata, o_sram_we
    );

endinterface

// File: rtl/sram_port_mux.sv
// Registered SRAM port: recorder writes take the port, otherwise playback addresses it.
// Read data is registered once on its way back to the player.
module sram_port_mux #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic [DATA_W-1:0] play_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            play_data  <= '0;
        end else begin
            sram_we   <= wr_en;
            play_data <= rdata;
            // Address holds its last value when neither a write nor playback owns the port
            if (wr_en) begin
                sram_addr  <= wr_addr;
                sram_wdata <= wr_data;
            end else if (rd_en) begin
                sram_addr <= rd_addr;
            end
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: key decoding, recorder/player command pulses,
// recorded-length tracking and ownership of the single SRAM port.
module rec_play_ctrl #(
    parameter int ADDR_W = audio_pkg::ADDR_W,
    parameter int DATA_W = audio_pkg::DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rec_play_ctrl_if.master       bus,
    output logic [2:0]            o_state,
    output logic [ADDR_W:0]       o_rec_len
);
    import audio_pkg::*;

    ctrl_state_e       state;
    logic [ADDR_W-1:0] addr_q;
    logic              key_start;
    logic              key_pause;
    logic              key_stop;
    logic              wr_evt;
    logic              wr_last;
    logic              play_end;
    logic              rd_en;

    // Priority stop > pause > start: only the winning key is seen by the FSM
    assign key_stop  = bus.i_key_stop;
    assign key_pause = bus.i_key_pause & ~bus.i_key_stop;
    assign key_start = bus.i_key_start & ~bus.i_key_pause & ~bus.i_key_stop;

    // A recorder address step closes the sample at the previous address
    assign wr_evt   = (state == ST_REC) && (bus.i_rec_addr != addr_q);
    assign wr_last  = wr_evt && (addr_q == '1);
    assign play_end = (state == ST_PLAY) && ({1'b0, bus.i_play_addr} >= o_rec_len);
    assign rd_en    = (state == ST_PLAY) || (state == ST_PLAY_PAUSE);
    assign o_state  = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            addr_q           <= '0;
            o_rec_len        <= '0;
            bus.o_rec_start  <= 1'b0;
            bus.o_rec_pause  <= 1'b0;
            bus.o_rec_stop   <= 1'b0;
            bus.o_play_start <= 1'b0;
            bus.o_play_pause <= 1'b0;
            bus.o_play_stop  <= 1'b0;
        end else begin
            addr_q           <= bus.i_rec_addr;
            bus.o_rec_start  <= 1'b0;
            bus.o_rec_pause  <= 1'b0;
            bus.o_rec_stop   <= 1'b0;
            bus.o_play_start <= 1'b0;
            bus.o_play_pause <= 1'b0;
            bus.o_play_stop  <= 1'b0;
            if (wr_evt) begin
                o_rec_len <= {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
            end
            case (state)
                ST_IDLE: begin
                    if (key_start) begin
                        if (!bus.i_mode) begin
                            state           <= ST_REC;
                            bus.o_rec_start <= 1'b1;
                            o_rec_len       <= '0;
                        end else if (o_rec_len != '0) begin
                            state            <= ST_PLAY;
                            bus.o_play_start <= 1'b1;
                        end
                    end
                end
                ST_REC: begin
                    // Filling the last word ends the take exactly like a stop key
                    if (wr_last || key_stop) begin
                        state          <= ST_IDLE;
                        bus.o_rec_stop <= 1'b1;
                    end else if (key_pause) begin
                        state           <= ST_REC_PAUSE;
                        bus.o_rec_pause <= 1'b1;
                    end
                end
                ST_REC_PAUSE: begin
                    if (key_stop) begin
                        state          <= ST_IDLE;
                        bus.o_rec_stop <= 1'b1;
                    end else if (key_start) begin
                        state           <= ST_REC;
                        bus.o_rec_start <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (play_end || key_stop) begin
                        state           <= ST_IDLE;
                        bus.o_play_stop <= 1'b1;
                    end else if (key_pause) begin
                        state            <= ST_PLAY_PAUSE;
                        bus.o_play_pause <= 1'b1;
                    end
                end
                ST_PLAY_PAUSE: begin
                    if (key_stop) begin
                        state           <= ST_IDLE;
                        bus.o_play_stop <= 1'b1;
                    end else if (key_start) begin
                        state            <= ST_PLAY;
                        bus.o_play_start <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram_port_mux (
        .clk        (i_clk),
        .rst        (i_rst),
        .wr_en      (wr_evt),
        .wr_addr    (addr_q),
        .wr_data    (bus.i_rec_data),
        .rd_en      (rd_en),
        .rd_addr    (bus.i_play_addr),
        .rdata      (bus.i_sram_rdata),
        .sram_addr  (bus.o_sram_addr),
        .sram_wdata (bus.o_sram_wdata),
        .sram_we    (bus.o_sram_we),
        .play_data  (bus.o_play_data)
    );

endmodule

// File: doc/rec_play_ctrl.md
# rec_play_ctrl

Top-level sequencer for the audio record/playback path. Turns single-cycle key pulses into start/pause/stop pulses for the recorder and the player. Owns the single SRAM port: it issues writes for recorder samples and addresses reads for the player. It also tracks the recorded length so playback auto-stops at the end of the take.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample/SRAM word width

Ports:
- i_clk  in  1  system clock; one clock for everything.
- i_rst  in  1  synchronous, active-high reset.
- i_key_start  in  1  one-cycle pulse: start or resume.
- i_key_pause  in  1  one-cycle pulse: pause.
- i_key_stop  in  1  one-cycle pulse: stop.
- i_mode  in  1  0 = record, 1 = play; sampled only on start from IDLE.
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle command pulses to the recorder.
- i_rec_addr  in  ADDR_W  recorder's current sample address.
- i_rec_data  in  DATA_W  recorder's current sample.
- o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle command pulses to the player.
- i_play_addr  in  ADDR_W  player's requested read address.
- o_play_data  out  DATA_W  SRAM read data returned to the player.
- o_sram_addr  out  ADDR_W  SRAM address.
- o_sram_wdata  out  DATA_W  SRAM write data.
- o_sram_we  out  1  active-high write strobe.
- i_sram_rdata  in  DATA_W  SRAM read data.
- o_state  out  3  current FSM state code.
- o_rec_len  out  ADDR_W+1  number of valid recorded words.

## Operation
- States: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
- Key priority when keys coincide: stop > pause > start. Only the winner acts.
- Transitions from IDLE on start:
  - i_mode=0: go to REC, pulse o_rec_start, clear o_rec_len to 0.
  - i_mode=1 and o_rec_len≠0: go to PLAY, pulse o_play_start.
  - i_mode=1 and o_rec_len=0: start is ignored.
- Transitions from REC / PLAY:
  - pause: go to REC_PAUSE / PLAY_PAUSE and pulse the matching pause output.
  - stop: go to IDLE and pulse the matching stop output.
  - start: ignored.
- Transitions from REC_PAUSE / PLAY_PAUSE:
  - start: return to REC / PLAY and pulse the matching start output. The recorder/player treats this as resume.
  - stop: go to IDLE and pulse the matching stop output.
  - pause: ignored.
- i_mode is ignored outside IDLE.
- Write detection in REC:
  - Registered copy addr_q tracks i_rec_addr every cycle in all states.
  - In REC, i_rec_addr ≠ addr_q marks a completed sample at address addr_q, paired with the held i_rec_data.
  - On that event, issue one SRAM write of {addr_q, i_rec_data}.
  - Set o_rec_len ← addr_q + 1.
- Full condition: a write to address 2^ADDR_W−1 sets o_rec_len = 2^ADDR_W, pulses o_rec_stop and goes to IDLE.
- Reads: in PLAY and PLAY_PAUSE, o_sram_addr follows i_play_addr and o_sram_we=0. o_play_data = i_sram_rdata, registered.
- End of take: in PLAY, {0,i_play_addr} ≥ o_rec_len pulses o_play_stop and goes to IDLE. This is checked before key decoding.
- IDLE / REC_PAUSE: o_sram_we=0; o_sram_addr holds its last value.
- o_rec_len is retained across IDLE and playback, and cleared only by a record start or reset.

## Timing
- Reset values:
  - o_state = IDLE.
  - All command pulses = 0.
  - o_sram_we = 0.
  - o_sram_addr = 0, o_sram_wdata = 0.
  - o_play_data = 0.
  - o_rec_len = 0.
  - addr_q = 0.
- Reset mid-record or mid-play returns to the reset values on the next edge. No stop pulse is emitted.
- Key → command pulse and state change: 1 cycle, both registered. Each pulse is high for exactly one cycle.
- Address change → o_sram_we high: 1 cycle later, for exactly one cycle, with o_sram_addr/o_sram_wdata valid in the same cycle.
- The recorder address changes no faster than once per 17 cycles, so back-to-back writes are never required.
- Write on the same cycle as stop/pause: the write still completes and o_rec_len updates.
- i_play_addr → o_sram_addr: 1 cycle. i_sram_rdata → o_play_data: 1 cycle.
- End-of-take → o_play_stop: 1 cycle after i_play_addr reaches o_rec_len.

## Structure
- Shared package (audio_pkg):
  - state enum ctrl_state_e;
  - ADDR_W / DATA_W constants;
  - the state encodings above, reused by the display/debug logic.
- One sub-module, sram_port_mux, holds the registered SRAM address/data/we selection and the read-data register. The FSM, key priority logic and length tracking live in rec_play_ctrl.

## Test plan
- Record path: reset, then start with i_mode=0 → o_rec_start at cycle+1. Step i_rec_addr 0→1→2 with data 0xA5A5, 0x1234 → two single-cycle writes (addr 0, 0xA5A5), (addr 1, 0x1234); o_rec_len=2.
- Priority: start+pause+stop in one cycle while in REC → only o_rec_stop; state IDLE; o_rec_len unchanged.
- Playback: from the recording above, start with i_mode=1 → o_play_start. Drive i_play_addr 0,1,2 → o_sram_addr follows with 1-cycle lag, then o_play_stop one cycle after addr 2; state IDLE.
- Guards: play start with o_rec_len=0 → no pulse, stays IDLE. Pause in PLAY then start → o_play_pause, then o_play_start, state PLAY.
- Wrap/full: force i_rec_addr 0xFFFFF→0x00000 in REC → write to 0xFFFFF, o_rec_len=0x100000, o_rec_stop, state IDLE.
- Reset mid-REC after 3 writes → all outputs at reset values next cycle; o_rec_len=0.
